// File: rtl/dmem_responder.sv
// dmem_responder: single-port word memory behind a req/ready, rvalid
// handshake with a fixed, parameterised response latency.
//
// Handshake: a request is accepted on a rising edge where req=1 and ready=1;
// ready is high only while the responder is idle. Each accepted request yields
// exactly one rvalid pulse, LATENCY+1 cycles later. rdata/err are meaningful
// only while rvalid=1 and read as zero otherwise. There is no back-pressure on
// the response side.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  LAT_M1     = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Storage array; deliberately has no reset.
    logic [31:0] mem [0:DEPTH_WORDS-1];

    // Transaction that is about to be answered: with LATENCY=0 the response
    // is formed on the accept edge itself, so the live inputs are used.
    logic [31:0]      resp_addr;
    logic             resp_we;
    logic             resp_fault;
    logic [IDX_W-1:0] resp_idx;

    // Select the transaction source and decode fault and word index.
    always_comb begin
        resp_addr  = (state_q == S_IDLE) ? addr : addr_q;
        resp_we    = (state_q == S_IDLE) ? we   : we_q;
        resp_fault = (|resp_addr[1:0]) || (resp_addr >= BYTE_LIMIT);
        resp_idx   = resp_addr[IDX_W+1:2];
    end

    // Next-state, capture registers and registered response outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (LATENCY == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // RESP lasts a single cycle, so state_d==S_RESP only on the entry edge;
        // memory is read there, before any store of this transaction commits.
        ready_d  = (state_d == S_IDLE);
        rvalid_d = (state_d == S_RESP);
        err_d    = (state_d == S_RESP) && resp_fault;
        rdata_d  = 32'd0;
        if ((state_d == S_RESP) && !resp_we && !resp_fault) begin
            rdata_d = mem[resp_idx];
        end
    end

    // Control and capture flops; reset overrides every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Store commit on the edge that ends RESP; a reset on that edge cancels it.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == S_RESP) && we_q && !err_q) begin
            mem[addr_q[IDX_W+1:2]] <= wdata_q;
        end
    end

    // Reset silences the response outputs immediately, so a transaction
    // abandoned in its RESP cycle never shows an rvalid pulse.
    always_comb begin
        ready  = ready_q;
        rvalid = rvalid_q && !reset;
        err    = err_q && !reset;
        rdata  = reset ? 32'd0 : rdata_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: randomized load/store traffic scored against a
// word-array reference model, directed reset/fault/boundary scenarios, and a
// second instance built with LATENCY=0 for back-to-back timing.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset, req, we;
  logic [31:0] addr, wdata;
  logic        ready, rvalid, err;
  logic [31:0] rdata;

  logic        reset0, req0, we0;
  logic [31:0] addr0, wdata0;
  logic        ready0, rvalid0, err0;
  logic [31:0] rdata0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset0), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .ready(ready0), .rvalid(rvalid0), .rdata(rdata0), .err(err0)
  );

  // ---------------- scoreboard ----------------
  int compared   = 0;
  int mismatched = 0;

  logic [32:0] exp_q[$];      // {err, rdata}
  int          exp_cyc_q[$];  // cycle count at the negedge where rvalid is due
  logic [31:0] ref_mem [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: word array indexed by byte address / 4.
  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              output logic [32:0] resp);
    if ((a % 4 != 0) || (a >= DEPTH * 4)) begin
      resp = {1'b1, 32'h0};
    end else if (w) begin
      ref_mem[a / 4] = d;
      resp = {1'b0, 32'h0};
    end else begin
      resp = {1'b0, ref_mem[a / 4]};
    end
  endtask

  // ---------------- monitor ----------------
  logic [32:0] mon_e;
  int          mon_c;
  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("rdata", rdata, mon_e[31:0]);
        check("err", {31'd0, err}, {31'd0, mon_e[32]});
        check("rvalid_cycle", 32'(cyc), 32'(mon_c));
      end
    end else begin
      check("idle_rdata", rdata, 32'd0);
      check("idle_err", {31'd0, err}, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return $urandom;
      1:       return 32'(DEPTH * 4 + $urandom_range(0, 15));
      2:       return 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      default: return 32'($urandom_range(0, DEPTH - 1) * 4);
    endcase
  endfunction

  task automatic junk_inputs(input logic r);
    req = r; we = 1'($urandom); addr = rand_addr(); wdata = $urandom;
  endtask

  // Called just after a rising edge. Issues one request, waits for ready and
  // scores the expected response. With junk=1 req stays high carrying garbage
  // while the responder is busy; none of it may be accepted.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input bit junk);
    int guard;
    logic [32:0] e;
    guard = 0;
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    while (ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      check("ready_timeout", 32'd0, 32'd1);
      req = 1'b0;
      return;
    end
    model_access(w, a, d, e);
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc + 1 + LAT);
    @(posedge clk); #1;
    if (junk) begin
      junk_inputs(1'b1);
      repeat (LAT) begin
        @(posedge clk); #1;
        junk_inputs(1'b1);
      end
    end
    junk_inputs(1'b0);
  endtask

  // Counts cycles with ready low right after an accept (txn with junk=0).
  task automatic check_busy_cycles(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check(name, 32'(n), 32'(LAT + 1));
    @(posedge clk); #1;
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(0, 3)) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [32:0] e;
  logic [31:0] v0;
  int          guard;

  initial begin
    reset = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h0; wdata = 32'h0;
    reset0 = 1'b1; req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;

    // Reset with req held high: nothing may be accepted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_rvalid", {31'd0, rvalid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; req = 1'b0;
    @(negedge clk);
    check("post_reset_ready", {31'd0, ready}, 32'd1);
    check("post_reset_rvalid", {31'd0, rvalid}, 32'd0);
    @(posedge clk); #1;

    // Preload every word through ordinary stores.
    for (int i = 0; i < DEPTH; i++) txn(1'b1, 32'(i * 4), $urandom, 1'b0);

    // Store then load the same word, with busy-time checks.
    txn(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    check_busy_cycles("store_busy_cycles");
    txn(1'b0, 32'h10, 32'h0, 1'b0);
    check_busy_cycles("load_busy_cycles");

    // Faulting stores leave memory alone.
    txn(1'b1, 32'h13, 32'hCAFEF00D, 1'b1);
    txn(1'b1, 32'(DEPTH * 4), 32'hCAFEF00D, 1'b1);
    txn(1'b0, 32'h10, 32'h0, 1'b1);
    txn(1'b0, 32'h0, 32'h0, 1'b1);
    txn(1'b0, 32'h11, 32'h0, 1'b0);

    // Last word.
    txn(1'b1, 32'(DEPTH * 4 - 4), 32'hFFFFFFFF, 1'b0);
    txn(1'b0, 32'(DEPTH * 4 - 4), 32'h0, 1'b0);
    txn(1'b0, 32'h0, 32'h0, 1'b0);

    // Reset lands on the RESP cycle of a store: no pulse, no commit.
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678;
    guard = 0;
    @(negedge clk);
    while (ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    junk_inputs(1'b0);
    repeat (LAT) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("resp_reset_rvalid", {31'd0, rvalid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    txn(1'b0, 32'h20, 32'h0, 1'b0);

    // Reset during WAIT with req held: the held request is accepted right after.
    idle_gap();
    req = 1'b1; we = 1'b0; addr = 32'h4; wdata = 32'h0;
    guard = 0;
    @(negedge clk);
    while (ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("wait_reset_rvalid", {31'd0, rvalid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("wait_reset_ready", {31'd0, ready}, 32'd1);
    model_access(1'b0, 32'h4, 32'h0, e);
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc + 1 + LAT);
    @(posedge clk); #1;
    junk_inputs(1'b0);

    // Random traffic.
    for (int i = 0; i < 150; i++) begin
      idle_gap();
      txn(1'($urandom_range(0, 1)), rand_addr(), $urandom, 1'($urandom_range(0, 1)));
    end

    // Drain outstanding responses.
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin @(posedge clk); guard++; end
    check("drain_outstanding", 32'(exp_q.size()), 32'd0);

    // LATENCY=0 instance: store, then back-to-back loads with req held high.
    v0 = $urandom;
    @(posedge clk); #1;
    reset0 = 1'b0; req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wdata0 = v0;
    @(negedge clk);
    check("l0_ready_first", {31'd0, ready0}, 32'd1);
    @(posedge clk); #1;
    we0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i % 2 == 0) begin
        check("l0_rvalid", {31'd0, rvalid0}, 32'd1);
        check("l0_ready_busy", {31'd0, ready0}, 32'd0);
        check("l0_rdata", rdata0, (i == 0) ? 32'd0 : v0);
        check("l0_err", {31'd0, err0}, 32'd0);
      end else begin
        check("l0_ready_idle", {31'd0, ready0}, 32'd1);
        check("l0_rvalid_idle", {31'd0, rvalid0}, 32'd0);
      end
    end
    req0 = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
